// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Holds the FSM state enum, sweep geometry and a small bit-insert helper.
package tt_sweep_ctrl_pkg;

    localparam int N_VEC = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic [N_VEC-1:0] set_bit(
        input logic [N_VEC-1:0] vec,
        input logic [IDX_W-1:0] pos,
        input logic             val
    );
        logic [N_VEC-1:0] res;
        res      = vec;
        res[pos] = val;
        return res;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag.
// Used to hold each gate input vector for a fixed number of settle cycles.
module tt_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority; the count saturates at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 16 input combinations of a 4-input gate, records its truth table
// and compares it against a golden table. All outputs come straight from flops.
module tt_sweep_ctrl
    import tt_sweep_ctrl_pkg::*;
#(
    parameter int               SETTLE_CYC = 2,
    parameter logic [N_VEC-1:0] EXPECTED   = 16'h6847
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IDX_W-1:0] gate_in,
    input  logic             gate_out,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] tt,
    output logic             valid,
    output logic             match
);

    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(N_VEC - 1);

    state_e           state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [IDX_W-1:0] gate_in_q, gate_in_d;
    logic [N_VEC-1:0] shadow_q,  shadow_d;
    logic [N_VEC-1:0] tt_q,      tt_d;
    logic             valid_q,   valid_d;
    logic             match_q,   match_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;

    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;

    tt_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_RELOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gate_in_d  = gate_in_q;
        shadow_d   = shadow_q;
        tt_d       = tt_q;
        valid_d    = valid_q;
        match_d    = match_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                gate_in_d = '0;
                if (start && !abort) begin
                    state_d    = SETTLE;
                    idx_d      = '0;
                    shadow_d   = '0;
                    valid_d    = 1'b0;
                    match_d    = 1'b0;
                    timer_load = 1'b1;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    gate_in_d = '0;
                end else if (timer_zero) begin
                    state_d = SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            SAMPLE: begin
                if (abort) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    gate_in_d = '0;
                end else begin
                    shadow_d = set_bit(shadow_q, idx_q, gate_out);
                    if (idx_q == LAST_IDX) begin
                        // Commit on entry to DONE so tt/valid/match line up with the done pulse.
                        state_d   = DONE;
                        gate_in_d = '0;
                        tt_d      = shadow_d;
                        valid_d   = 1'b1;
                        match_d   = (shadow_d == EXPECTED);
                    end else begin
                        state_d    = SETTLE;
                        idx_d      = idx_q + 1'b1;
                        gate_in_d  = idx_q + 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d   = IDLE;
                idx_d     = '0;
                gate_in_d = '0;
            end

            default: begin
                state_d   = IDLE;
                idx_d     = '0;
                gate_in_d = '0;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gate_in_q <= '0;
            shadow_q  <= '0;
            tt_q      <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gate_in_q <= gate_in_d;
            shadow_q  <= shadow_d;
            tt_q      <= tt_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign gate_in = gate_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign tt      = tt_q;
    assign valid   = valid_q;
    assign match   = match_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: instance A uses SETTLE_CYC=2 with a
// combinational gate model, instance B uses SETTLE_CYC=1 with a 1-cycle-latency gate.
module tb_tt_sweep_ctrl;

    localparam int          SETTLE_A = 2;
    localparam int          SETTLE_B = 1;
    localparam logic [15:0] GOLDEN   = 16'h6847;

    logic        clk;
    logic        rst_n;

    logic        start_a, abort_a, gate_out_a;
    logic [3:0]  gate_in_a;
    logic        busy_a, done_a, valid_a, match_a;
    logic [15:0] tt_a;

    logic        start_b, abort_b;
    logic        gate_out_b = 1'b0;
    logic [3:0]  gate_in_b;
    logic        busy_b, done_b, valid_b, match_b;
    logic [15:0] tt_b;

    logic        use_and_a;
    logic [15:0] gate_tbl_a;
    logic [15:0] gate_tbl_b;
    logic [15:0] last_tt_a;

    int vectors;
    int miscompares;

    tt_sweep_ctrl #(
        .SETTLE_CYC (SETTLE_A),
        .EXPECTED   (GOLDEN)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .abort    (abort_a),
        .gate_in  (gate_in_a),
        .gate_out (gate_out_a),
        .busy     (busy_a),
        .done     (done_a),
        .tt       (tt_a),
        .valid    (valid_a),
        .match    (match_a)
    );

    tt_sweep_ctrl #(
        .SETTLE_CYC (SETTLE_B),
        .EXPECTED   (GOLDEN)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .abort    (abort_b),
        .gate_in  (gate_in_b),
        .gate_out (gate_out_b),
        .busy     (busy_b),
        .done     (done_b),
        .tt       (tt_b),
        .valid    (valid_b),
        .match    (match_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate: either an arbitrary lookup table or a 4-input AND.
    function automatic logic gate_eval(input logic use_and, input logic [15:0] tbl, input logic [3:0] x);
        if (use_and) return &x;
        return tbl[x];
    endfunction

    // Reference truth table: evaluate the gate at every input combination.
    function automatic logic [15:0] model_tt(input logic use_and, input logic [15:0] tbl);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = gate_eval(use_and, tbl, 4'(i));
        return r;
    endfunction

    assign gate_out_a = gate_eval(use_and_a, gate_tbl_a, gate_in_a);

    always @(posedge clk) gate_out_b <= gate_tbl_b[gate_in_b];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({gate_in_a, busy_a, done_a, tt_a, valid_a, match_a} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_a: got gi=%h busy=%b done=%b tt=%h valid=%b match=%b expected all zero",
                     gate_in_a, busy_a, done_a, tt_a, valid_a, match_a);
        end
        vectors++;
        if ({gate_in_b, busy_b, done_b, tt_b, valid_b, match_b} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_b: got gi=%h busy=%b done=%b tt=%h valid=%b match=%b expected all zero",
                     gate_in_b, busy_b, done_b, tt_b, valid_b, match_b);
        end
        tick();
        tick();
        rst_n = 1'b1;
        last_tt_a = 16'h0000;
        tick();
        vectors++;
        if (busy_a !== 1'b0 || gate_in_a !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got busy=%b gi=%h expected 0 0", busy_a, gate_in_a);
        end
    endtask

    // Full sweep on instance A; optional stray start pulses while busy must be ignored.
    task automatic run_sweep_a(input string name, input logic use_and, input logic [15:0] tbl, input bit poke_start);
        logic [15:0] exp_tt;
        logic [3:0]  exp_gi;
        int          period;
        period     = SETTLE_A + 1;
        use_and_a  = use_and;
        gate_tbl_a = tbl;
        exp_tt     = model_tt(use_and, tbl);
        start_a    = 1'b1;
        abort_a    = 1'b0;
        tick();
        start_a = 1'b0;
        vectors++;
        if (busy_a !== 1'b1 || valid_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_accept: got busy=%b valid=%b expected 1 0", name, busy_a, valid_a);
        end
        for (int k = 0; k < 16 * period; k++) begin
            exp_gi = 4'(k / period);
            vectors++;
            if (gate_in_a !== exp_gi || done_a !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s_seq k=%0d: got gi=%h done=%b expected gi=%h done=0", name, k, gate_in_a, done_a, exp_gi);
            end
            start_a = poke_start && ($urandom_range(0, 3) == 0);
            tick();
        end
        start_a = 1'b0;
        vectors++;
        if (done_a !== 1'b1 || tt_a !== exp_tt || valid_a !== 1'b1 || match_a !== (exp_tt == GOLDEN)) begin
            miscompares++;
            $display("[TB] FAIL %s_done: got done=%b tt=%h valid=%b match=%b expected 1 %h 1 %b",
                     name, done_a, tt_a, valid_a, match_a, exp_tt, (exp_tt == GOLDEN));
        end
        last_tt_a = exp_tt;
        tick();
        vectors++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || gate_in_a !== 4'h0 || tt_a !== exp_tt || valid_a !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_after: got done=%b busy=%b gi=%h tt=%h valid=%b expected 0 0 0 %h 1",
                     name, done_a, busy_a, gate_in_a, tt_a, valid_a, exp_tt);
        end
        tick();
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_no_queue: got busy=%b expected 0", name, busy_a);
        end
    endtask

    task automatic test_golden();
        run_sweep_a("golden", 1'b0, GOLDEN, 1'b0);
    endtask

    task automatic test_and_gate();
        run_sweep_a("and4", 1'b1, 16'h0000, 1'b0);
    endtask

    task automatic test_random_tables();
        logic [15:0] tbl;
        for (int i = 0; i < 4; i++) begin
            tbl = (i == 2) ? GOLDEN : 16'($urandom);
            run_sweep_a("random", 1'b0, tbl, 1'b1);
        end
    endtask

    task automatic test_abort();
        int abort_k;
        int seen_done;
        abort_k    = 21 + $urandom_range(0, 2);
        use_and_a  = 1'b0;
        gate_tbl_a = 16'($urandom);
        start_a    = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < abort_k; k++) tick();
        vectors++;
        if (gate_in_a !== 4'd7) begin
            miscompares++;
            $display("[TB] FAIL abort_at_vec7: got gi=%h expected 7", gate_in_a);
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        vectors++;
        if (busy_a !== 1'b0 || gate_in_a !== 4'h0 || done_a !== 1'b0 || valid_a !== 1'b0 || tt_a !== last_tt_a) begin
            miscompares++;
            $display("[TB] FAIL abort_state: got busy=%b gi=%h done=%b valid=%b tt=%h expected 0 0 0 0 %h",
                     busy_a, gate_in_a, done_a, valid_a, tt_a, last_tt_a);
        end
        seen_done = 0;
        for (int k = 0; k < 60; k++) begin
            if (done_a !== 1'b0 || valid_a !== 1'b0 || busy_a !== 1'b0) seen_done++;
            tick();
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet: got %0d bad cycles expected 0", seen_done);
        end
        run_sweep_a("restart", 1'b0, GOLDEN, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        int bad;
        bad     = 0;
        start_a = 1'b1;
        abort_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy_a !== 1'b0 || gate_in_a !== 4'h0) bad++;
        end
        start_a = 1'b0;
        abort_a = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL start_abort_idle: got %0d busy cycles expected 0", bad);
        end
    endtask

    task automatic test_async_reset();
        int stop_k;
        int bad;
        stop_k     = 27 + $urandom_range(0, 2);
        use_and_a  = 1'b0;
        gate_tbl_a = 16'($urandom);
        start_a    = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < stop_k; k++) tick();
        vectors++;
        if (gate_in_a !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL rst_at_vec9: got gi=%h expected 9", gate_in_a);
        end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({gate_in_a, busy_a, done_a, tt_a, valid_a, match_a} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_midcycle: got gi=%h busy=%b done=%b tt=%h valid=%b match=%b expected all zero",
                     gate_in_a, busy_a, done_a, tt_a, valid_a, match_a);
        end
        tick();
        rst_n     = 1'b1;
        last_tt_a = 16'h0000;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_quiet: got %0d active cycles expected 0", bad);
        end
        run_sweep_a("post_reset", 1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic test_latency_gate();
        int          done_k;
        logic [15:0] exp_tt;
        logic [3:0]  exp_gi;
        int          bad;
        gate_tbl_b = 16'($urandom);
        exp_tt     = model_tt(1'b0, gate_tbl_b);
        start_b    = 1'b1;
        tick();
        start_b = 1'b0;
        done_k  = -1;
        bad     = 0;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            if (done_b === 1'b1) begin
                done_k = k;
            end else begin
                exp_gi = 4'(k / (SETTLE_B + 1));
                if (k < 32 && gate_in_b !== exp_gi) bad++;
                tick();
            end
        end
        vectors++;
        if (done_k != 32 || bad != 0) begin
            miscompares++;
            $display("[TB] FAIL latency_timing: got done at %0d with %0d gi errors expected 32 and 0", done_k, bad);
        end
        vectors++;
        if (tt_b !== exp_tt || valid_b !== 1'b1 || match_b !== (exp_tt == GOLDEN)) begin
            miscompares++;
            $display("[TB] FAIL latency_tt: got tt=%h valid=%b match=%b expected %h 1 %b",
                     tt_b, valid_b, match_b, exp_tt, (exp_tt == GOLDEN));
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start_a     = 1'b0;
        abort_a     = 1'b0;
        start_b     = 1'b0;
        abort_b     = 1'b0;
        use_and_a   = 1'b0;
        gate_tbl_a  = 16'h0000;
        gate_tbl_b  = 16'h0000;
        last_tt_a   = 16'h0000;
        rst_n       = 1'b1;

        test_reset();
        test_golden();
        test_and_gate();
        test_random_tables();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        test_latency_gate();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, meaning the number of cycles that gate_in is held before each sample (legal range 1..255).
REQ-002 SHALL have parameter EXPECTED, 16 bits, default 16'h6847, meaning the golden truth table compared on completion.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancels a sweep in progress.
REQ-007 SHALL have port gate_in, output, 4 bits: drives the 4-input gate; bit k drives gate input k.
REQ-008 SHALL have port gate_out, input, 1 bit: the gate's response.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 SHALL have port tt, output, 16 bits: the last completed truth table.
REQ-012 SHALL have port valid, output, 1 bit: tt holds a completed, un-superseded result.
REQ-013 SHALL have port match, output, 1 bit: tt == EXPECTED, meaningful when valid=1.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE with start=1 and abort=0 SHALL go to SETTLE, set idx=0, drive gate_in=0, load the settle counter with SETTLE_CYC-1, and clear valid.
REQ-016 SETTLE SHALL hold gate_in=idx and decrement the counter; at counter=0 it SHALL go to SAMPLE.
REQ-017 In SAMPLE, shadow bit [idx] SHALL capture gate_out. If idx<15: idx+1, gate_in=idx+1, counter reloaded, back to SETTLE. If idx=15: go to DONE.
REQ-018 Each vector SHALL take exactly SETTLE_CYC+1 cycles, so a full sweep takes 16*(SETTLE_CYC+1) cycles from start accept to entering DONE.
REQ-019 DONE SHALL last one cycle with done=1, copy shadow to tt, set valid=1, register match = (shadow == EXPECTED), then return to IDLE.
REQ-020 Truth-table convention SHALL be: tt bit i = gate_out when gate_in = i.
REQ-021 start while busy SHALL be ignored, with no queuing.
REQ-022 start and abort both high in IDLE SHALL be handled as abort wins: stay in IDLE.
REQ-023 abort in SETTLE or SAMPLE SHALL return to IDLE next cycle with gate_in=0, no done pulse, and tt unchanged; valid stays 0 because it was cleared at start.
REQ-024 abort in DONE SHALL be ignored, so completion stands.
REQ-025 idx SHALL be 4 bits and never wrap within a sweep; the transition from 15 to DONE is terminal.
REQ-026 gate_in SHALL be 0 whenever in IDLE.
REQ-027 All outputs SHALL be registered, with no combinational path from gate_out to any output.

Reset
REQ-028 rst_n low SHALL force IDLE immediately, with gate_in=0, busy=0, done=0, tt=0, valid=0, match=0, idx=0 and counter=0.
REQ-029 Reset asserted mid-sweep SHALL discard the sweep; after release the block idles until a new start.

Structure
REQ-030 A shared package SHALL hold the state enum, N_VEC=16, and IDX_W=4.
REQ-031 A single sub-module tt_settle_timer SHALL implement the loadable down-counter with a zero flag.
REQ-032 The RTL SHALL be one FSM plus datapath registers, 120-400 lines total.

Verification
REQ-033 Gate model 0x6847, SETTLE_CYC=2, pulse start: done at cycle 48 after accept; tt=16'h6847; valid=1; match=1; gate_in sequence 0..15, each held 3 cycles.
REQ-034 Gate model 4-input AND, default EXPECTED: tt=16'h8000, match=0, valid=1.
REQ-035 Abort at vector 7, then restart with the 0x6847 model: no done after the abort; valid=0 until the second done; second result 16'h6847.
REQ-036 start and abort together in IDLE: busy stays 0, gate_in stays 0 for 10 cycles.
REQ-037 rst_n pulsed low at vector 9 (asynchronous, mid-cycle): outputs zero immediately; no done afterward; a fresh sweep yields the correct tt.
REQ-038 SETTLE_CYC=1 with a gate model that has 1-cycle output latency: tt is correct, and done arrives 32 cycles after accept.
